rs232_rx: RTL and testbench



---
 rtl/rs232_rx.sv | 214 +++++++++++++++++++++
 tb/tb_rs232_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx.sv
// UART receiver: 8N1, LSB first, 16x oversampling with 3-sample majority vote per bit.
// Define RS232_RX_PARITY_EN to add an even-parity bit before the stop bit and a parity_err strobe.
`timescale 1ns/1ps
module rs232_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUDRATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
`ifdef RS232_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV = (CLK_FREQ + BAUDRATE * 8) / (BAUDRATE * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
`ifdef RS232_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t        state, state_next;
    logic          rx_p0, rx_p1, rx_p2;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    sample_cnt;
    logic [3:0]    smp;
    logic          mid, wrap;
    logic          vote7, vote8;
    logic          bit_val;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;

    logic          cnt_clr, bit_take, idx_clr, idx_inc, data_load;
    logic          valid_next, ferr_next;
`ifdef RS232_RX_PARITY_EN
    logic          par_bit, par_take, perr_next;
`endif

    // Stage p0..p1 synchronise the pin; p2 holds the previous synchronised value for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // The counter is cleared on the start edge so each tick lands at a fixed sixteenth of the bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt   <= '0;
            sample_cnt <= 4'd0;
        end else if (cnt_clr) begin
            tick_cnt   <= '0;
            sample_cnt <= 4'd0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick)
                sample_cnt <= sample_cnt + 4'd1;
        end
    end

    // smp is the index of the sample this tick takes; 7/8/9 straddle the bit centre
    assign smp     = sample_cnt + 4'd1;
    assign mid     = tick && (smp == 4'd9);
    assign wrap    = tick && (sample_cnt == 4'd15);
    assign bit_val = majority(vote7, vote8, rx_p1);

    always_ff @(posedge clk) begin
        if (tick && smp == 4'd7)
            vote7 <= rx_p1;
        if (tick && smp == 4'd8)
            vote8 <= rx_p1;
        if (bit_take)
            shift[bit_idx] <= bit_val;
`ifdef RS232_RX_PARITY_EN
        if (par_take)
            par_bit <= bit_val;
`endif
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        bit_take   = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        data_load  = 1'b0;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_take   = 1'b0;
        perr_next  = 1'b0;
`endif
        case (state)
            WAIT_HIGH: begin
                if (tick && rx_p1)
                    state_next = IDLE;
            end
            IDLE: begin
                if (rx_p2 && !rx_p1) begin
                    state_next = START;
                    cnt_clr    = 1'b1;
                end
            end
            START: begin
                if (mid && bit_val) begin
                    state_next = IDLE;
                end else if (wrap) begin
                    state_next = DATA;
                    idx_clr    = 1'b1;
                end
            end
            DATA: begin
                if (mid)
                    bit_take = 1'b1;
                if (wrap) begin
                    if (bit_idx == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
`ifdef RS232_RX_PARITY_EN
            PARITY: begin
                if (mid)
                    par_take = 1'b1;
                if (wrap)
                    state_next = STOP;
            end
`endif
            // Deciding at mid-stop leaves the rest of the stop bit free to catch the next start edge
            STOP: begin
                if (mid) begin
                    data_load = 1'b1;
                    if (bit_val) begin
                        state_next = IDLE;
`ifdef RS232_RX_PARITY_EN
                        if (^{shift, par_bit})
                            perr_next = 1'b1;
                        else
                            valid_next = 1'b1;
`else
                        valid_next = 1'b1;
`endif
                    end else begin
                        state_next = WAIT_HIGH;
                        ferr_next  = 1'b1;
                    end
                end
            end
            default: state_next = WAIT_HIGH;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= WAIT_HIGH;
            bit_idx   <= 3'd0;
            data      <= 8'd0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            valid     <= valid_next;
            frame_err <= ferr_next;
`ifdef RS232_RX_PARITY_EN
            parity_err <= perr_next;
`endif
            if (idx_clr)
                bit_idx <= 3'd0;
            else if (idx_inc)
                bit_idx <= bit_idx + 3'd1;
            if (data_load)
                data <= shift;
        end
    end

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx: serial frames driven onto rx, received bytes and strobes checked.
// The clock is 18.432 MHz so the divider is exact at 115200 baud and runs stay short.
`timescale 1ns/1ps
module tb_rs232_rx;

    localparam int  CLK_FREQ = 18_432_000;
    localparam int  BAUDRATE = 115_200;
    localparam real HALF_NS  = 1.0e9 / (2.0 * CLK_FREQ);
    localparam real BIT_NS   = 1.0e9 / BAUDRATE;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    logic [7:0] rxq[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         n_vec    = 0;
    int         n_miss   = 0;

    rs232_rx #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #(HALF_NS) clk = ~clk;

    always @(negedge clk) begin
        if (valid)
            rxq.push_back(data);
        if (frame_err)
            ferr_cnt <= ferr_cnt + 1;
        if (valid && frame_err)
            both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got(input int i);
        if (i < rxq.size())
            return {24'h0, rxq[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_val);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_val;
        #(bit_ns);
    endtask

    initial begin
        int  qb;
        int  fb;
        real rate;
        logic [7:0] bb[3];

        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);

        // single 0x55; busy must drop before the stop bit ends
        qb = rxq.size(); fb = ferr_cnt;
        send_byte(8'h55, BIT_NS, 1'b1);
        @(negedge clk);
        chk("t55_busy", 32'(busy), 32'h0);
        chk("t55_cnt", 32'(rxq.size() - qb), 32'd1);
        chk("t55_data", got(qb), 32'h55);
        chk("t55_ferr", 32'(ferr_cnt - fb), 32'd0);
        #(BIT_NS);

        // back-to-back frames, no idle gap
        bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'hA5;
        qb = rxq.size(); fb = ferr_cnt;
        for (int i = 0; i < 3; i++)
            send_byte(bb[i], BIT_NS, 1'b1);
        @(negedge clk);
        chk("b2b_cnt", 32'(rxq.size() - qb), 32'd3);
        chk("b2b_d0", got(qb), 32'h00);
        chk("b2b_d1", got(qb + 1), 32'hFF);
        chk("b2b_d2", got(qb + 2), 32'hA5);
        chk("b2b_ferr", 32'(ferr_cnt - fb), 32'd0);
        #(BIT_NS);

        // 2 us glitch is a false start
        qb = rxq.size(); fb = ferr_cnt;
        rx = 1'b0;
        #(2000.0);
        rx = 1'b1;
        #(BIT_NS);
        @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'h0);
        chk("glitch_cnt", 32'(rxq.size() - qb), 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt - fb), 32'd0);
        send_byte(8'h3C, BIT_NS, 1'b1);
        @(negedge clk);
        chk("g3c_cnt", 32'(rxq.size() - qb), 32'd1);
        chk("g3c_data", got(qb), 32'h3C);
        #(BIT_NS);

        // bad stop bit followed by a 12-bit break
        qb = rxq.size(); fb = ferr_cnt;
        send_byte(8'h81, BIT_NS, 1'b0);
        #(12.0 * BIT_NS);
        @(negedge clk);
        chk("brk_ferr", 32'(ferr_cnt - fb), 32'd1);
        chk("brk_valid", 32'(rxq.size() - qb), 32'd0);
        chk("brk_busy", 32'(busy), 32'h1);
        chk("brk_data", 32'(data), 32'h81);
        rx = 1'b1;
        #(BIT_NS);
        send_byte(8'h7E, BIT_NS, 1'b1);
        @(negedge clk);
        chk("b7e_cnt", 32'(rxq.size() - qb), 32'd1);
        chk("b7e_data", got(qb), 32'h7E);
        #(BIT_NS);

        // reset pulse during data bit 4 of 0xC3
        qb = rxq.size(); fb = ferr_cnt;
        fork
            send_byte(8'hC3, BIT_NS, 1'b1);
            begin
                #(5.4 * BIT_NS);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                chk("mrst_data", 32'(data), 32'h0);
                chk("mrst_valid", 32'(valid), 32'h0);
                chk("mrst_ferr", 32'(frame_err), 32'h0);
                chk("mrst_busy", 32'(busy), 32'h1);
                rst = 1'b1;
            end
        join
        #(BIT_NS);
        chk("mrst_cnt", 32'(rxq.size() - qb), 32'd0);
        chk("mrst_fe", 32'(ferr_cnt - fb), 32'd0);
        send_byte(8'h18, BIT_NS, 1'b1);
        @(negedge clk);
        chk("r18_cnt", 32'(rxq.size() - qb), 32'd1);
        chk("r18_data", got(qb), 32'h18);
        #(BIT_NS);

        // +/-3% sender rate, two frames back-to-back each
        for (int k = 0; k < 2; k++) begin
            rate = (k == 0) ? 1.03 : 0.97;
            qb = rxq.size(); fb = ferr_cnt;
            send_byte(8'h96, BIT_NS / rate, 1'b1);
            send_byte(8'h96, BIT_NS / rate, 1'b1);
            @(negedge clk);
            chk($sformatf("ppm%0d_cnt", k), 32'(rxq.size() - qb), 32'd2);
            chk($sformatf("ppm%0d_d0", k), got(qb), 32'h96);
            chk($sformatf("ppm%0d_d1", k), got(qb + 1), 32'h96);
            chk($sformatf("ppm%0d_ferr", k), 32'(ferr_cnt - fb), 32'd0);
            #(BIT_NS);
        end

        chk("strobe_overlap", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
